// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the instruction fetch stage.
package pipeline_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0;
   typedef enum logic [1:0] {BOOT, RUN, DROP} fetch_state_t;
endpackage

// File: rtl/pipeline_fetch_if.sv
// pipeline_fetch_if: instruction memory request/ack bus between fetch (master) and memory (slave).
interface pipeline_fetch_if;
   import pipeline_pkg::*;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_rdata;
   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/pipeline_fetch.sv
// pipeline_fetch: single-outstanding instruction fetch with stall, redirect and in-flight drop.
module pipeline_fetch
   import pipeline_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    f_stall,
   input  logic                    f_redirect,
   input  logic [XLEN-1:0]         f_redirect_pc,
   pipeline_fetch_if.master        imem,
   output logic                    f_available,
   output logic                    f_output,
   output logic [XLEN-1:0]         f_pc,
   output logic [XLEN-1:0]         f_instr
);
   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, tgt_q, tgt_d, f_pc_q, f_pc_d, f_instr_q, f_instr_d;
   logic            pending_q, pending_d, out_valid_q, out_valid_d, req, take;

   always_comb begin
      req = state_q == DROP ? 1'b1 :
            state_q == RUN  ? (pending_q | ((~out_valid_q | ~f_stall) & ~f_redirect)) : 1'b0;
      take = req & imem.imem_ack;
      state_d = state_q;
      pc_d = pc_q;
      tgt_d = tgt_q;
      out_valid_d = out_valid_q;
      f_pc_d = f_pc_q;
      f_instr_d = f_instr_q;
      pending_d = req & ~imem.imem_ack;
      case (state_q)
         BOOT: begin
            state_d = RUN;
            pc_d = f_redirect ? f_redirect_pc : pc_q;
         end
         DROP: begin
            tgt_d = f_redirect ? f_redirect_pc : tgt_q;
            if (take) begin
               pc_d = tgt_d;
               state_d = RUN;
            end
         end
         default: begin
            // a redirect racing an outstanding request must swallow its response
            if (f_redirect) begin
               out_valid_d = 1'b0;
               if (pending_q & ~imem.imem_ack) begin
                  tgt_d = f_redirect_pc;
                  state_d = DROP;
               end else begin
                  pc_d = f_redirect_pc;
               end
            end else if (take) begin
               f_instr_d = imem.imem_rdata;
               f_pc_d = pc_q;
               out_valid_d = 1'b1;
               pc_d = pc_q + 32'd4;
            end else if (~f_stall) begin
               out_valid_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q <= RESET_PC;
         tgt_q <= '0;
         pending_q <= 1'b0;
         out_valid_q <= 1'b0;
         f_pc_q <= '0;
         f_instr_q <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         tgt_q <= tgt_d;
         pending_q <= pending_d;
         out_valid_q <= out_valid_d;
         f_pc_q <= f_pc_d;
         f_instr_q <= f_instr_d;
      end
   end

   assign imem.imem_req = req;
   assign imem.imem_addr = pc_q;
   assign f_available = out_valid_q;
   assign f_output = out_valid_q;
   assign f_pc = f_pc_q;
   assign f_instr = f_instr_q;
endmodule

// File: doc/pipeline_fetch.md
PIPELINE_FETCH -- requirements
Module: pipeline_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'hBFC0_0000, first fetch address after reset.
REQ-002 Port: clk  in  1  sole clock, all state on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: f_stall  in  1  from pipeline control; 0 = output consumed at this edge.
REQ-005 Port: f_redirect  in  1  jump/flush request from pipeline control.
REQ-006 Port: f_redirect_pc  in  32  redirect target, sampled when f_redirect=1.
REQ-007 Port: imem_req  out  1  instruction memory request.
REQ-008 Port: imem_addr  out  32  request address, stable while imem_req=1 and imem_ack=0.
REQ-009 Port: imem_ack  in  1  response valid; may assert in the same cycle as imem_req.
REQ-010 Port: imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-011 Port: f_available  out  1  equals internal out_valid.
REQ-012 Port: f_output  out  1  equals internal out_valid.
REQ-013 Port: f_pc / f_instr  out  32 each  held instruction address / word.

Function
REQ-014 States: BOOT, RUN, DROP; internal regs pc, tgt, pending, out_valid.
REQ-015 BOOT: imem_req=0; next edge -> RUN (pc<=f_redirect_pc if f_redirect=1).
REQ-016 RUN: imem_req = pending | ((~out_valid | ~f_stall) & ~f_redirect); imem_addr=pc.
REQ-017 DROP: imem_req=1, imem_addr=pc (old address); response discarded.
REQ-018 pending <= imem_req & ~imem_ack every edge; once raised, imem_req stays 1 until ack.
REQ-019 RUN, ack, no redirect: f_instr<=imem_rdata, f_pc<=pc, out_valid<=1, pc<=pc+4 (mod 2^32 wrap).
REQ-020 RUN, no ack, out_valid=1, f_stall=0: out_valid<=0.
REQ-021 RUN, f_redirect, no pending: out_valid<=0, pc<=f_redirect_pc, stay RUN.
REQ-022 RUN, f_redirect, pending, no ack: out_valid<=0, tgt<=f_redirect_pc, -> DROP.
REQ-023 RUN, f_redirect and ack same cycle: data discarded, pc<=f_redirect_pc, stay RUN.
REQ-024 DROP, f_redirect: tgt<=f_redirect_pc (latest wins).
REQ-025 DROP, ack: pc<=f_redirect ? f_redirect_pc : tgt, -> RUN; out_valid stays 0.
REQ-026 Latency: req with same-cycle ack in cycle N -> f_output=1 in N+1; throughput 1/cycle with zero-wait memory and f_stall=0.
REQ-027 f_pc/f_instr hold value while out_valid=1 and f_stall=1.
REQ-028 No combinational path from imem_req to f_available/f_output.

Reset
REQ-029 rst_n=0 asynchronously forces: state BOOT, pc=RESET_PC, tgt=0, pending=0, out_valid=0, f_pc=0, f_instr=0, imem_req=0.
REQ-030 Reset mid-request abandons the transaction; memory ack arriving in BOOT is ignored.

Structure
REQ-031 Package pipeline_pkg holds fetch_state_t {BOOT, RUN, DROP}, XLEN=32, NOP_INSTR=32'h0.
REQ-032 Single flat module; no sub-modules.

Verification
REQ-033 Reset release, zero-wait memory, f_stall=0 -> imem_addr BFC0_0000, BFC0_0004, BFC0_0008 on consecutive cycles; f_pc follows one cycle later.
REQ-034 f_output=1, f_stall=1 for 3 cycles -> imem_req=0, f_pc/f_instr frozen; release -> next fetch issued same cycle.
REQ-035 Ack delayed 3 cycles -> imem_addr stable, f_output=0 until cycle after ack.
REQ-036 f_redirect to 0000_0100 with no pending -> out_valid cleared, next imem_addr=0000_0100.
REQ-037 Redirect to 0000_0200 while request to BFC0_0010 pending, ack 2 cycles later -> ack data discarded, f_output stays 0, next imem_addr=0000_0200.
REQ-038 rst_n low during pending request -> outputs at reset values immediately; fetch restarts at BFC0_0000.
